// File: rtl/oled_state_sequencer_pkg.sv
// Shared definitions for the OLED level sequencer, renderer and driver:
// FSM encoding, level constants and the frame geometry.
package oled_state_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } seq_state_t;

  localparam logic [2:0] LVL_BLANK = 3'd0;
  localparam logic [2:0] LVL_FIRST = 3'd1;
  localparam logic [2:0] LVL_LAST  = 3'd4;

  // Pixels per OLED frame (96 x 64).
  localparam int unsigned FRAME_PIXELS = 6144;

  // Dwell counter width; never narrower than one bit so DWELL_TICKS=1 still elaborates.
  function automatic int cnt_width(input int ticks);
    return (ticks > 1) ? $clog2(ticks) : 1;
  endfunction

endpackage

// File: rtl/oled_state_sequencer_rise_detect.sv
// Registered rising-edge detector: rise is combinational from din and the prior sample.
// No latency beyond the sampling register; no flow control.
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic din_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_q <= 1'b0;
    end else begin
      din_q <= din;
    end
  end

  assign rise = din & ~din_q;

endmodule

// File: rtl/oled_state_sequencer.sv
// Steps the renderer level 1..4 on a tick-based dwell; start/pause and stop buttons.
// Button to FSM: one edge; FSM to state: next frame_begin plus one cycle. No backpressure.
module oled_state_sequencer #(
  parameter int unsigned DWELL_TICKS = 500,
  parameter bit          LOOP        = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       btn_start,
  input  logic       btn_stop,
  input  logic       frame_begin,
  output logic [2:0] state,
  output logic       busy,
  output logic       done
);
  import oled_state_sequencer_pkg::*;

  localparam int CW = cnt_width(DWELL_TICKS);
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL_TICKS - 1);

  logic start_rise;
  logic stop_rise;

  rise_detect u_start_rise (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (btn_start),
    .rise  (start_rise)
  );

  rise_detect u_stop_rise (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (btn_stop),
    .rise  (stop_rise)
  );

  seq_state_t    fsm, fsm_nx;
  logic [2:0]    step, step_nx;
  logic [2:0]    target, target_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          done_nx;

  // Priority: stop, then start, then dwell expiry; ticks only count in RUN.
  always_comb begin
    fsm_nx  = fsm;
    step_nx = step;
    cnt_nx  = cnt;
    done_nx = 1'b0;
    if (stop_rise) begin
      fsm_nx  = IDLE;
      step_nx = LVL_FIRST;
      cnt_nx  = '0;
    end else if (start_rise) begin
      case (fsm)
        IDLE: begin
          fsm_nx  = RUN;
          step_nx = LVL_FIRST;
          cnt_nx  = '0;
        end
        RUN:     fsm_nx = PAUSE;
        PAUSE:   fsm_nx = RUN;
        default: fsm_nx = IDLE;
      endcase
    end else if (fsm == RUN && tick) begin
      if (cnt == CNT_LAST) begin
        cnt_nx = '0;
        if (step < LVL_LAST) begin
          step_nx = step + 3'd1;
        end else if (LOOP) begin
          step_nx = LVL_FIRST;
        end else begin
          fsm_nx  = IDLE;
          step_nx = LVL_FIRST;
          done_nx = 1'b1;
        end
      end else begin
        cnt_nx = cnt + 1'b1;
      end
    end
  end

  assign target_nx = (fsm_nx == IDLE) ? LVL_BLANK : step_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm    <= IDLE;
      step   <= LVL_FIRST;
      cnt    <= '0;
      target <= LVL_BLANK;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      fsm    <= fsm_nx;
      step   <= step_nx;
      cnt    <= cnt_nx;
      target <= target_nx;
      busy   <= (fsm_nx != IDLE);
      done   <= done_nx;
    end
  end

  // Commit uses the pre-edge target so a frame never mixes two levels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LVL_BLANK;
    end else if (frame_begin) begin
      state <= target;
    end
  end

endmodule

// File: doc/oled_state_sequencer.md
# oled_state_sequencer

Sequences the 3-bit display `state` that drives the OLED concentric-rectangle renderer through levels 0→1→2→3→4. It responds to start/pause and stop buttons and holds each level for a programmable number of slow ticks. Level changes are committed only at OLED frame boundaries, so a frame never shows two levels. It sits between the debounced pushbuttons / tick divider and the renderer's `state` input.

## Interface
- `DWELL_TICKS`, default 500: number of `tick` pulses each level 1–4 is held; legal range ≥1.
- `LOOP`, default 0: 1 means that after level 4 the sequence restarts at 1; 0 means it returns to idle.
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `tick`  in  1  one-cycle clock-enable pulse from the divider (e.g. 1 kHz).
- `btn_start`  in  1  debounced level, start/pause/resume; acts on the rising edge.
- `btn_stop`  in  1  debounced level, abort; acts on the rising edge.
- `frame_begin`  in  1  one-cycle pulse from the OLED driver when `pixel_index` wraps to 0.
- `state`  out  3  level presented to the renderer: 0 = blank, 1–4 = rectangle levels.
- `busy`  out  1  high in RUN or PAUSE.
- `done`  out  1  one-cycle pulse when a non-looping sequence completes.

## Operation
- Edge detect: registered copies of `btn_start`/`btn_stop`. A rise is `btn & ~btn_q`. After reset, `btn_q` = 0, so a button already held high at reset produces one rise.
- FSM states:
  - IDLE: `target` = 0.
  - RUN: `target` = `step`.
  - PAUSE: `target` = `step`, and the dwell count is frozen.
- Transitions (priority: stop > start > dwell expiry):
  - Any state, stop rise → IDLE; `step` ← 1; `cnt` ← 0.
  - IDLE, start rise → RUN; `step` ← 1; `cnt` ← 0.
  - RUN, start rise → PAUSE. A `tick` arriving in the same cycle is ignored.
  - PAUSE, start rise → RUN. `cnt` is retained.
  - RUN, `tick`, `cnt` < DWELL_TICKS−1 → `cnt` ← `cnt`+1.
  - RUN, `tick`, `cnt` == DWELL_TICKS−1 → `cnt` ← 0, then:
    - if `step` < 4: `step` ← `step`+1;
    - else if LOOP=1: `step` ← 1;
    - else: go to IDLE and pulse `done` for one cycle, in the same cycle as the transition.
- `tick` outside RUN is ignored.
- Commit: `state` ← `target` on every edge where `frame_begin` = 1; otherwise `state` holds. `target` is the registered value present before that edge.
- `cnt` width is $clog2(DWELL_TICKS) with a minimum of 1; it never exceeds DWELL_TICKS−1.
- `step` is 3 bits and only ever holds 1–4.

## Timing
- Reset values: `state` = 0, `busy` = 0, `done` = 0, FSM = IDLE, `step` = 1, `cnt` = 0, `btn_q` = 0.
- Button rise to FSM change: 1 cycle after the rising sample (edge register plus FSM register).
- `busy` is a registered decode of the FSM and changes on the same edge as the FSM.
- FSM change to `state` change:
  - the first `frame_begin` strictly after the `target` update, plus 1 cycle;
  - worst case one frame period plus 1 cycle.
- Simultaneous `frame_begin` and a `target` update: `state` takes the old `target`. The new value appears at the next frame.
- Several `target` changes within one frame: only the last value before `frame_begin` is shown. Intermediate levels are legally skipped.
- DWELL_TICKS=1: the level advances on every `tick` in RUN.
- Reset asserted mid-sequence: all registers go immediately to their reset values, and `state` = 0 without waiting for a frame.
- `done` is never asserted when LOOP=1.

## Structure
- A shared package holds:
  - FSM state typedef: IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2;
  - level constants LVL_BLANK = 3'd0, LVL_FIRST = 3'd1, LVL_LAST = 3'd4;
  - the OLED frame size constant 6144, shared with the renderer and the driver.
- One sub-module, `rise_detect`, instantiated twice: 1-bit registered rising-edge detector with async active-low reset.
- Everything else (FSM, dwell counter, step register, frame-commit register) stays flat in `oled_state_sequencer`.

## Test plan
- Reset release with buttons low, several frames → `state` = 0, `busy` = 0, `done` never pulses.
- DWELL_TICKS=3, LOOP=0; start rise; `tick` every 10 cycles; `frame_begin` every 4 cycles → `state` shows 1, 2, 3, 4 (each level visible in ≥1 frame), then 0; exactly one `done` pulse coincident with `busy` falling.
- Same setup, start pressed again during level 2 → `state` stays 2 for 20 further ticks; third start rise → resumes, and level 3 appears after the remaining dwell ticks.
- Stop and start rising in the same cycle during RUN → IDLE, `busy` = 0; `state` = 0 at the next `frame_begin` + 1.
- `frame_begin` held low while stepping 1→2→3 → `state` stays at its old value; the first `frame_begin` afterwards commits 3 directly.
- LOOP=1, 10 ticks per level → sequence 1, 2, 3, 4, 1, 2 observed, no `done`; assert `rst_n` = 0 mid level 2 → `state`, `busy` and `done` = 0 immediately, without a clock edge.
